// File: rtl/door_pkg.sv
// door_pkg: shared types and defaults for the keypad door lock.
// Holds the FSM state enum, default code digits and idle timeout.
package door_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    OPEN  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [3:0] DEF_CODE0 = 4'd1;
  localparam logic [3:0] DEF_CODE1 = 4'd3;
  localparam logic [3:0] DEF_CODE2 = 4'd2;
  localparam logic [3:0] DEF_CODE3 = 4'd4;

  localparam int DEF_TIMEOUT = 10;

  // Expected digit for a given entry position.
  function automatic logic [3:0] code_at(
    input logic [1:0] i,
    input logic [3:0] c0,
    input logic [3:0] c1,
    input logic [3:0] c2,
    input logic [3:0] c3
  );
    logic [3:0] r;
    case (i)
      2'd0:    r = c0;
      2'd1:    r = c1;
      2'd2:    r = c2;
      default: r = c3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/door_press_detect.sv
// door_press_detect: turns the level keypad value into a press strobe.
// A held key is one press; the same digit again needs a 0 in between.
module door_press_detect (
  input  logic [3:0] btn,
  input  logic       clk,
  input  logic       reset,
  output logic       press,
  output logic [3:0] digit
);

  logic [3:0] btn_q;

  // Previous-cycle key value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 4'd0;
    end else begin
      btn_q <= btn;
    end
  end

  assign press = (btn != 4'd0) && (btn != btn_q);
  assign digit = btn;

endmodule

// File: rtl/door_system.sv
// door_system: keypad door-lock controller with 4-digit code.
// Judges the code only after the 4th digit; idle timeouts re-lock.
module door_system
  import door_pkg::*;
#(
  parameter logic [3:0] CODE0   = DEF_CODE0,
  parameter logic [3:0] CODE1   = DEF_CODE1,
  parameter logic [3:0] CODE2   = DEF_CODE2,
  parameter logic [3:0] CODE3   = DEF_CODE3,
  parameter int         TIMEOUT = DEF_TIMEOUT
) (
  input  logic [3:0] btn,
  input  logic       clk,
  input  logic       reset,
  output logic       y,
  output logic       green,
  output logic       red
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);

  logic          press;
  logic [3:0]    digit;
  state_t        state;
  state_t        next;
  logic [1:0]    idx;
  logic          match;
  logic [CW-1:0] cnt;
  logic          first;
  logic [3:0]    want;
  logic          hit;
  logic          ok;
  logic          timeout;
  logic          y_d;
  logic          green_d;
  logic          red_d;

  door_press_detect u_press (
    .btn   (btn),
    .clk   (clk),
    .reset (reset),
    .press (press),
    .digit (digit)
  );

  // Any press outside ENTRY starts a fresh attempt at digit 0.
  assign first   = (state != ENTRY);
  assign want    = first ? CODE0
                         : code_at(idx, CODE0, CODE1, CODE2, CODE3);
  assign hit     = (digit == want);
  assign ok      = match && hit;
  assign timeout = (cnt == TLAST) && !press;

  // State register and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      y     <= 1'b0;
      green <= 1'b0;
      red   <= 1'b0;
    end else begin
      state <= next;
      y     <= y_d;
      green <= green_d;
      red   <= red_d;
    end
  end

  // Next-state: presses advance entry, and a press beats a timeout.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (press) next = ENTRY;
      end
      ENTRY: begin
        if (press) begin
          if (idx == 2'd3) next = ok ? OPEN : ERROR;
        end else if (timeout) begin
          next = ERROR;
        end
      end
      OPEN, ERROR: begin
        if (press)        next = ENTRY;
        else if (timeout) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Output decode from the upcoming state; strike fires on OPEN entry.
  always_comb begin
    y_d     = 1'b0;
    green_d = 1'b0;
    red_d   = 1'b0;
    green_d = (next == OPEN);
    red_d   = (next == ERROR);
    y_d     = (next == OPEN) && (state != OPEN);
  end

  // Digit index, running match flag and saturating idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= 2'd0;
      match <= 1'b0;
      cnt   <= '0;
    end else begin
      if (press) begin
        if (first) begin
          idx   <= 2'd1;
          match <= hit;
        end else begin
          idx   <= idx + 2'd1;
          match <= match && hit;
        end
      end
      if (press || (next != state) || (state == IDLE)) begin
        cnt <= '0;
      end else if (cnt != TMAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_door_system.sv
// tb_door_system: randomized and directed checks of door_system.
// Reference model tracks entered digits, lock status and idle time.
module tb_door_system;

  localparam int TMO = 10;

  logic [3:0] btn;
  logic       clk;
  logic       reset;
  logic       y;
  logic       green;
  logic       red;

  int checks;
  int fails;

  door_system dut (
    .btn   (btn),
    .clk   (clk),
    .reset (reset),
    .y     (y),
    .green (green),
    .red   (red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         code [4] = '{1, 3, 2, 4};
  int         digs [$];
  bit         mo;
  bit         me;
  bit         my;
  int         idle;
  logic [3:0] prevb;

  function automatic logic [2:0] expv();
    return {my, mo, me};
  endfunction

  task automatic model_reset();
    digs.delete();
    mo    = 0;
    me    = 0;
    my    = 0;
    idle  = 0;
    prevb = 4'd0;
  endtask

  task automatic model_step(input logic [3:0] b);
    bit p;
    bit good;
    p     = (b != 4'd0) && (b != prevb);
    prevb = b;
    my    = 0;
    if (p) begin
      idle = 0;
      if (digs.size() == 0) begin
        mo = 0;
        me = 0;
      end
      digs.push_back(int'(b));
      if (digs.size() == 4) begin
        good = 1;
        for (int i = 0; i < 4; i++)
          if (digs[i] != code[i]) good = 0;
        mo = good;
        me = !good;
        my = good;
        digs.delete();
      end
    end else if (digs.size() > 0 || mo || me) begin
      idle++;
      if (idle == TMO) begin
        if (digs.size() > 0) begin
          me = 1;
          digs.delete();
        end else begin
          mo = 0;
          me = 0;
        end
        idle = 0;
      end
    end
  endtask

  task automatic tick(input logic [3:0] b);
    btn = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    btn   = 4'd0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({y, green, red} !== 3'b000) begin
      fails++;
      $display("FAIL reset_async got=%b want=000", {y, green, red});
    end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(4'd0);
      checks++;
      if ({y, green, red} !== 3'b000) begin
        fails++;
        $display("FAIL reset_idle got=%b want=000", {y, green, red});
      end
    end
  endtask

  task automatic test_correct_code();
    int h;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      h = $urandom_range(1, 2);
      for (int k = 0; k < h; k++) begin
        tick(4'(code[i]));
        checks++;
        if ({y, green, red} !== expv()) begin
          fails++;
          $display("FAIL correct_model got=%b want=%b", {y, green, red}, expv());
        end
        if (i == 3 && k == 0) begin
          checks++;
          if ({y, green, red} !== 3'b110) begin
            fails++;
            $display("FAIL correct_unlock got=%b want=110", {y, green, red});
          end
        end
      end
    end
    tick(4'd0);
    checks++;
    if ({y, green, red} !== 3'b010) begin
      fails++;
      $display("FAIL correct_ypulse got=%b want=010", {y, green, red});
    end
  endtask

  task automatic test_wrong_code();
    logic [3:0] s [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      tick(s[i]);
      checks++;
      if ({y, green, red} !== expv()) begin
        fails++;
        $display("FAIL wrong_model got=%b want=%b", {y, green, red}, expv());
      end
      if (i == 0) begin
        checks++;
        if (green !== 1'b0) begin
          fails++;
          $display("FAIL wrong_green_drop got=%b want=0", green);
        end
      end
    end
    checks++;
    if ({y, green, red} !== 3'b001) begin
      fails++;
      $display("FAIL wrong_error got=%b want=001", {y, green, red});
    end
  endtask

  task automatic test_entry_timeout();
    apply_reset();
    tick(4'd1);
    tick(4'd3);
    for (int k = 1; k <= TMO; k++) begin
      tick(4'd0);
      checks++;
      if (red !== (k == TMO) || {y, green, red} !== expv()) begin
        fails++;
        $display("FAIL entry_timeout k=%0d got=%b want_red=%0d model=%b",
                 k, {y, green, red}, (k == TMO), expv());
      end
    end
    apply_reset();
    tick(4'd1);
    tick(4'd3);
    for (int k = 1; k < TMO; k++) tick(4'd0);
    tick(4'd2);
    checks++;
    if ({y, green, red} !== 3'b000 || expv() !== 3'b000) begin
      fails++;
      $display("FAIL entry_press_wins got=%b want=000", {y, green, red});
    end
    tick(4'd4);
    checks++;
    if ({y, green, red} !== 3'b110) begin
      fails++;
      $display("FAIL entry_late_unlock got=%b want=110", {y, green, red});
    end
  endtask

  task automatic test_relock();
    for (int k = 1; k <= TMO + 3; k++) begin
      tick(4'd0);
      checks++;
      if (green !== (k < TMO) || {y, green, red} !== expv()) begin
        fails++;
        $display("FAIL relock k=%0d got=%b want_green=%0d model=%b",
                 k, {y, green, red}, (k < TMO), expv());
      end
    end
  endtask

  task automatic test_held_keys();
    logic [3:0] s1 [10] = '{1, 1, 1, 1, 1, 3, 3, 3, 2, 4};
    logic [3:0] s2 [5]  = '{3, 0, 3, 2, 4};
    apply_reset();
    foreach (s1[i]) begin
      tick(s1[i]);
      checks++;
      if ({y, green, red} !== expv()) begin
        fails++;
        $display("FAIL held_model i=%0d got=%b want=%b", i, {y, green, red}, expv());
      end
    end
    checks++;
    if (green !== 1'b1) begin
      fails++;
      $display("FAIL held_open got=%b want=1", green);
    end
    apply_reset();
    foreach (s2[i]) tick(s2[i]);
    checks++;
    if ({y, green, red} !== 3'b001) begin
      fails++;
      $display("FAIL repeat_two_digits got=%b want=001", {y, green, red});
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(4'd1);
    tick(4'd3);
    tick(4'd2);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({y, green, red} !== 3'b000) begin
      fails++;
      $display("FAIL areset_entry got=%b want=000", {y, green, red});
    end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    tick(4'd0);
    tick(4'd1);
    tick(4'd3);
    tick(4'd2);
    tick(4'd4);
    checks++;
    if ({y, green, red} !== 3'b110) begin
      fails++;
      $display("FAIL areset_discard got=%b want=110", {y, green, red});
    end
    #2;
    reset = 1'b1;
    btn   = 4'd1;
    #1;
    checks++;
    if ({y, green, red} !== 3'b000) begin
      fails++;
      $display("FAIL areset_open got=%b want=000", {y, green, red});
    end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    tick(4'd1);
    tick(4'd3);
    tick(4'd2);
    tick(4'd4);
    checks++;
    if ({y, green, red} !== 3'b110 || expv() !== 3'b110) begin
      fails++;
      $display("FAIL areset_held_first got=%b want=110", {y, green, red});
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    int r;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        for (int i = 0; i < 4; i++) begin
          tick(4'(code[i]));
          checks++;
          if ({y, green, red} !== expv()) begin
            fails++;
            $display("FAIL random_code n=%0d got=%b want=%b", n, {y, green, red}, expv());
          end
        end
      end else if (r == 1) begin
        for (int i = 0; i < TMO + 2; i++) begin
          tick(4'd0);
          checks++;
          if ({y, green, red} !== expv()) begin
            fails++;
            $display("FAIL random_idle n=%0d got=%b want=%b", n, {y, green, red}, expv());
          end
        end
      end else begin
        if (r < 8)       b = 4'd0;
        else if (r < 16) b = 4'(code[$urandom_range(0, 3)]);
        else             b = 4'($urandom_range(0, 15));
        tick(b);
        checks++;
        if ({y, green, red} !== expv()) begin
          fails++;
          $display("FAIL random n=%0d btn=%0d got=%b want=%b", n, b, {y, green, red}, expv());
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    btn    = 4'd0;
    model_reset();
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_entry_timeout();
    test_relock();
    test_held_keys();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
